// File: rtl/stream_mux_n_to_1.sv
// N:1 valid/ready stream multiplexer with packet locking on in_last and a registered output stage.
// Optional feature: define RR_ARB_EN to replace the sel input with a round-robin arbiter in IDLE.
module stream_mux_n_to_1 #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic [SW-1:0]  cur_sel
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SW:0]   N_L     = N[SW:0];
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  state_t        state_r;
  logic [W-1:0]  out_data_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic [SW-1:0] cur_sel_r;

  logic [SW-1:0] grant_s;
  logic          grant_ok_s;
  logic          can_load_s;
  logic          load_ok_s;
  logic [W-1:0]  chan_data_s;
  logic          chan_valid_s;
  logic          chan_last_s;
  logic          xfer_s;
  logic [N-1:0]  in_ready_s;

`ifdef RR_ARB_EN
  logic [SW-1:0] rr_ptr_r;
  logic [SW-1:0] rr_grant_s;
  logic          rr_found_s;
  logic [SW:0]   rr_idx_s;

  // Cyclic search for the first valid channel starting after the last packet's channel.
  always_comb begin
    rr_grant_s = '0;
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      rr_idx_s = {1'b0, rr_ptr_r} + (SW+1)'(k);
      if (rr_idx_s >= N_L) begin
        rr_idx_s = rr_idx_s - N_L;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      if (!rr_found_s && in_valid[rr_idx_s[SW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_grant_s = rr_idx_s[SW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end
`endif

  // Grant source: locked channel mid-packet, otherwise sel or the arbiter.
  always_comb begin
    if (state_r == LOCKED) begin
      grant_s    = cur_sel_r;
      grant_ok_s = ({1'b0, cur_sel_r} < N_L);
    end else begin
`ifdef RR_ARB_EN
      grant_s    = rr_grant_s;
      grant_ok_s = rr_found_s;
`else
      grant_s    = sel;
      grant_ok_s = ({1'b0, sel} < N_L);
`endif
    end
  end

  assign can_load_s = !out_valid_r || out_ready;
  // Reset also closes every ready so nothing is accepted on a reset edge.
  assign load_ok_s  = grant_ok_s && can_load_s && !rst;

  // AND-OR channel select and one-hot ready generation.
  always_comb begin
    chan_data_s  = '0;
    chan_valid_s = 1'b0;
    chan_last_s  = 1'b0;
    in_ready_s   = '0;
    for (int i = 0; i < N; i++) begin
      chan_data_s   = chan_data_s  | (in_data[i*W +: W] & {W{grant_s == SW'(i)}});
      chan_valid_s  = chan_valid_s | (in_valid[i] && (grant_s == SW'(i)));
      chan_last_s   = chan_last_s  | (in_last[i]  && (grant_s == SW'(i)));
      in_ready_s[i] = load_ok_s && (grant_s == SW'(i));
    end
  end

  assign xfer_s   = load_ok_s && chan_valid_s;
  assign in_ready = in_ready_s;

  // Output register, packet FSM and (optionally) round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      cur_sel_r   <= '0;
`ifdef RR_ARB_EN
      rr_ptr_r    <= LAST_CH;
`endif
    end else if (xfer_s) begin
      out_data_r  <= chan_data_s;
      out_last_r  <= chan_last_s;
      out_valid_r <= 1'b1;
      cur_sel_r   <= grant_s;
      case (state_r)
        IDLE: begin
          state_r <= chan_last_s ? IDLE : LOCKED;
`ifdef RR_ARB_EN
          rr_ptr_r <= grant_s;
`endif
        end
        LOCKED:  state_r <= chan_last_s ? IDLE : LOCKED;
        default: state_r <= IDLE;
      endcase
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign cur_sel   = cur_sel_r;

endmodule
